// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } debounce_state_t;

  localparam int unsigned SYNC_STAGES       = 2;
  localparam int unsigned PRESS_COUNT_WIDTH = 8;

endpackage : debounce_pkg

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw level in, clean level and edge pulses out.
// Optional press_count field is present when BUTTON_DEBOUNCER_PRESS_COUNT_EN is defined.
interface button_debouncer_if
  import debounce_pkg::*;
();

  logic btn_in;
  logic debounced;
  logic rise_pulse;
  logic fall_pulse;
`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
  logic [PRESS_COUNT_WIDTH-1:0] press_count;
`endif

  // Debouncer side: consumes the raw level, produces the conditioned outputs.
  modport master (
    input  btn_in,
    output debounced,
    output rise_pulse,
`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
    output press_count,
`endif
    output fall_pulse
  );

  // Consumer side (button pad driver and downstream counters).
  modport slave (
    output btn_in,
    input  debounced,
    input  rise_pulse,
`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
    input  press_count,
`endif
    input  fall_pulse
  );

endinterface : button_debouncer_if

// File: rtl/debounce_timer.sv
// Stability timer: counts cycles while enabled, flags the last cycle of the window.
module debounce_timer #(
  parameter int unsigned CYCLES = 500000,
  parameter int unsigned WIDTH  = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [WIDTH-1:0] timer_q;
  logic [WIDTH-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable) begin
      timer_d = timer_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign done = (timer_q == WIDTH'(CYCLES - 1));

endmodule : debounce_timer

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw button level; emits clean level plus rise/fall pulses.
// Define BUTTON_DEBOUNCER_PRESS_COUNT_EN to add a wrapping 8-bit press counter.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMER_WIDTH     = 19
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.master bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync_c;

  debounce_state_t state_q;
  debounce_state_t state_d;
  logic            debounced_q;
  logic            debounced_d;
  logic            rise_q;
  logic            rise_d;
  logic            fall_q;
  logic            fall_d;

  logic timer_clear_c;
  logic timer_en_c;
  logic timer_done_c;

  // Two-flop synchronizer; only the last stage is visible to the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign btn_sync_c = sync_q[SYNC_STAGES-1];

  debounce_timer #(
    .CYCLES (DEBOUNCE_CYCLES),
    .WIDTH  (TIMER_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_c),
    .enable (timer_en_c),
    .done   (timer_done_c)
  );

  // Next-state and output logic; a reversal beats a coincident done.
  always_comb begin
    state_d       = state_q;
    debounced_d   = debounced_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    timer_en_c    = 1'b0;

    unique case (state_q)
      S_LOW: begin
        debounced_d = 1'b0;
        if (btn_sync_c) begin
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        timer_en_c = 1'b1;
        if (!btn_sync_c) begin
          state_d = S_LOW;
        end else if (timer_done_c) begin
          state_d     = S_HIGH;
          debounced_d = 1'b1;
          rise_d      = 1'b1;
        end
      end
      S_HIGH: begin
        debounced_d = 1'b1;
        if (!btn_sync_c) begin
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        timer_en_c = 1'b1;
        if (btn_sync_c) begin
          state_d = S_HIGH;
        end else if (timer_done_c) begin
          state_d     = S_LOW;
          debounced_d = 1'b0;
          fall_d      = 1'b1;
        end
      end
      default: begin
        state_d     = S_LOW;
        debounced_d = 1'b0;
      end
    endcase

    // Clear on entry into, and exit from, a wait window so the timer never wraps.
    timer_clear_c = !timer_en_c ||
                    !((state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOW;
      debounced_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      debounced_q <= debounced_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign bus.debounced  = debounced_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
  logic [PRESS_COUNT_WIDTH-1:0] press_count_q;

  // Counts accepted presses; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_count_q <= '0;
    end else if (rise_d) begin
      press_count_q <= press_count_q + PRESS_COUNT_WIDTH'(1);
    end
  end

  assign bus.press_count = press_count_q;
`endif

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a 4-cycle debounce window.
module tb_button_debouncer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_rise;

  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .TIMER_WIDTH     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bif.rise_pulse === 1'b1) n_rise++;
  endtask

  // One edge, then compare all three outputs.
  task automatic step_chk(input string tag, input int e, input bit deb, input bit rise, input bit fall);
    tick();
    check($sformatf("%s.deb@%0d", tag, e),  32'(bif.debounced),  32'(deb));
    check($sformatf("%s.rise@%0d", tag, e), 32'(bif.rise_pulse), 32'(rise));
    check($sformatf("%s.fall@%0d", tag, e), 32'(bif.fall_pulse), 32'(fall));
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    n_rise     = 0;
    reset      = 1'b1;
    bif.btn_in = 1'b1;

    // Reset held 3 cycles with button high: everything quiet.
    for (int e = 1; e <= 3; e++) step_chk("rst", e, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    // Button already high: accepted 7 edges after release.
    for (int e = 1; e <= 8; e++) step_chk("post_rst", e, e >= 7, e == 7, 1'b0);

    // Clean release from debounced=1.
    bif.btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) step_chk("release", e, e < 7, 1'b0, e == 7);

    // Clean press from idle low.
    bif.btn_in = 1'b1;
    for (int e = 1; e <= 8; e++) step_chk("press", e, e >= 7, e == 7, 1'b0);
    bif.btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) step_chk("release2", e, e < 7, 1'b0, e == 7);

    // Bounce 1,0,1,0 every 2 cycles then settle low: never accepted.
    for (int e = 1; e <= 16; e++) begin
      bif.btn_in = (e <= 2) || (e == 5) || (e == 6);
      step_chk("bounce", e, 1'b0, 1'b0, 1'b0);
    end

    // High for 4 cycles: reversal lands on the done cycle, so it is rejected.
    for (int e = 1; e <= 10; e++) begin
      bif.btn_in = (e <= 4);
      step_chk("glitch4", e, 1'b0, 1'b0, 1'b0);
    end

    // High for 5 cycles: accepted at edge 7, then released at edge 12.
    for (int e = 1; e <= 14; e++) begin
      bif.btn_in = (e <= 5);
      step_chk("hold5", e, (e >= 7) && (e < 12), e == 7, e == 12);
    end

    // Reset sampled at edge 6 abandons the wait; rise moves to edge 13.
    bif.btn_in = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      reset = (e == 6);
      step_chk("rst_mid", e, e >= 13, e == 13, 1'b0);
    end
    reset = 1'b0;

`ifdef BUTTON_DEBOUNCER_PRESS_COUNT_EN
    // Debounced is high here; reset must drop it with no fall pulse.
    reset = 1'b1;
    bif.btn_in = 1'b0;
    step_chk("pc_rst", 1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("pc_init", 32'(bif.press_count), 32'd0);
    n_rise = 0;
    for (int p = 0; p < 300; p++) begin
      bif.btn_in = 1'b1;
      for (int e = 0; e < 8; e++) tick();
      bif.btn_in = 1'b0;
      for (int e = 0; e < 8; e++) tick();
    end
    check("pc_rises", 32'(n_rise), 32'd300);
    check("pc_value", 32'(bif.press_count), 32'd44);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_button_debouncer
